alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Multi-cycle, width-parametrised successor to the processor's combinational ALU, using the same 4-bit opcode map. Single-cycle ops complete in one clock. MUL (shift-add) and DIV (restoring) iterate over WIDTH cycles so they do not set the critical path. Sits between the register-file read stage and writeback; the control unit drives i_start and stalls on o_busy. All outputs are registered, with no latches, and o_checkbranch is defined for every opcode.

Parameters:
WIDTH, 13, datapath width in bits (min 4).
CNTW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  launch operation; sampled only when o_busy=0
i_opcode  input  4  0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 XOR, 8 J, 9 BEQ, 10 BGT, 11 BLT, 12 BNE, 13 SW, 14 LD, 15 LSL
i_dataA  input  WIDTH  operand A (unsigned)
i_dataB  input  WIDTH  operand B (unsigned)
o_result  output  WIDTH  result, held until next completion
o_remainder  output  WIDTH  DIV remainder; 0 for all other ops
o_checkbranch  output  1  branch taken
o_ovf  output  1  ADD carry-out / SUB borrow / MUL high-half nonzero
o_divz  output  1  divide by zero occurred
o_busy  output  1  op in progress; i_start ignored
o_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counter and shift registers 0.
- Operand capture: i_opcode, i_dataA and i_dataB are latched on the accepted i_start. Operands may change afterwards.
- FSM states:
  - IDLE: i_start and op not MUL/DIV -> compute, register outputs, go to DONE. i_start and MUL/DIV -> ITER, o_busy=1, counter=0.
  - ITER: one partial step per cycle. After WIDTH steps -> DONE with results registered.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 -> IDLE. An i_start in DONE is ignored.
- Latency (start edge to o_done high): 1 cycle for simple ops, WIDTH+1 cycles for MUL/DIV. Throughput: one op per 2 cycles (simple) or WIDTH+2 cycles (MUL/DIV).
- o_busy=1 from the cycle after accept until DONE. An i_start while busy is ignored and not queued.
- Result rules (all WIDTH bits, unsigned):
  - ADD/SUB: modulo 2^WIDTH.
  - MUL: low WIDTH bits of the 2*WIDTH product.
  - DIV: quotient, with remainder on o_remainder.
  - AND/OR/XOR: bitwise.
  - J/SW/LD: A+B (address calc).
  - LSL: A<<B; result 0 if B>=WIDTH.
  - NOP: 0.
  - Branches (9-12): o_result=0.
- o_checkbranch: 1 only for a taken BEQ/BGT/BLT/BNE. Cleared to 0 on every other completion.
- o_ovf: meaningful only for ADD/SUB/MUL; 0 for all other ops.
- DIV by zero: no iteration; goes to DONE next cycle with o_result all ones, o_remainder=A, o_divz=1. o_divz is otherwise 0.
- All result/flag outputs update only at the transition into DONE and hold through IDLE.
- Reset mid-ITER: abort immediately, outputs to 0. No o_done pulse after release.

Test Plan:
- Reset and idle: assert i_rst_n=0 mid-cycle -> all outputs 0 asynchronously. Release, idle 5 cycles -> o_done never pulses.
- ADD wrap: ADD 8000+500 -> o_done 1 cycle later, o_result=308, o_ovf=1. Then SUB 5-7 -> 8190, o_ovf=1.
- MUL: MUL 100*50 -> o_busy high 13 cycles, o_done at cycle 14, o_result=5000, o_ovf=0. MUL 200*100 -> 3616, o_ovf=1.
- DIV: DIV 8191/7 -> 1170, o_remainder=1 at cycle 14. DIV 9/0 -> next cycle 8191, o_remainder=9, o_divz=1.
- Branch: BLT 3,5 -> o_checkbranch=1. Next ADD 1+1 -> o_checkbranch=0, o_result=2. BEQ 4,5 -> 0.
- Busy/abort:
  - i_start ADD during MUL ITER -> ignored; MUL result unchanged.
  - Drop i_rst_n at ITER cycle 6, release -> outputs 0, no o_done.
  - LSL 1<<13 -> 0.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, WIDTH-step shift-add MUL and restoring DIV.
// Results and flags are registered on entry to DONE and held until the next completion.
module alu_mc #(
    parameter int WIDTH = 13
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_dataA,
    input  logic [WIDTH-1:0] i_dataB,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_checkbranch,
    output logic             o_ovf,
    output logic             o_divz,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4,
                           OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7, OP_J   = 4'd8,
                           OP_BEQ = 4'd9, OP_BGT = 4'd10, OP_BLT = 4'd11, OP_BNE = 4'd12,
                           OP_SW  = 4'd13, OP_LD = 4'd14, OP_LSL = 4'd15;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              isdiv_q, isdiv_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]  result_q, result_d, rem_q, rem_d;
    logic              cb_q, cb_d, ovf_q, ovf_d, divz_q, divz_d, busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]    add_s, sub_s, mac, rs;
    logic [WIDTH+1:0]  dtry;

    always_comb begin
        add_s = {1'b0, i_dataA} + {1'b0, i_dataB};
        sub_s = {1'b0, i_dataA} - {1'b0, i_dataB};
        // MUL: {hi,lo} holds partial product with multiplier in lo, shifted right each step
        mac   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        // DIV: {hi,lo} holds partial remainder and dividend/quotient, shifted left each step
        rs    = {hi_q, lo_q[WIDTH-1]};
        dtry  = {1'b0, rs} - {2'b00, opb_q};

        state_d  = state_q;
        cnt_d    = cnt_q;
        isdiv_d  = isdiv_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        rem_d    = rem_q;
        cb_d     = cb_q;
        ovf_d    = ovf_q;
        divz_d   = divz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_opcode == OP_MUL || (i_opcode == OP_DIV && i_dataB != '0)) begin
                        state_d = ITER;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        isdiv_d = (i_opcode == OP_DIV);
                        opb_d   = (i_opcode == OP_MUL) ? i_dataA : i_dataB;
                        lo_d    = (i_opcode == OP_MUL) ? i_dataB : i_dataA;
                        hi_d    = '0;
                    end else begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = '0;
                        rem_d    = '0;
                        cb_d     = 1'b0;
                        ovf_d    = 1'b0;
                        divz_d   = 1'b0;
                        unique case (i_opcode)
                            OP_ADD: begin result_d = add_s[WIDTH-1:0]; ovf_d = add_s[WIDTH]; end
                            OP_SUB: begin result_d = sub_s[WIDTH-1:0]; ovf_d = sub_s[WIDTH]; end
                            OP_DIV: begin result_d = '1; rem_d = i_dataA; divz_d = 1'b1; end
                            OP_AND: result_d = i_dataA & i_dataB;
                            OP_OR:  result_d = i_dataA | i_dataB;
                            OP_XOR: result_d = i_dataA ^ i_dataB;
                            OP_J, OP_SW, OP_LD: result_d = add_s[WIDTH-1:0];
                            OP_BEQ: cb_d = (i_dataA == i_dataB);
                            OP_BGT: cb_d = (i_dataA > i_dataB);
                            OP_BLT: cb_d = (i_dataA < i_dataB);
                            OP_BNE: cb_d = (i_dataA != i_dataB);
                            OP_LSL: result_d = (i_dataB >= WIDTH'(WIDTH)) ? '0 : (i_dataA << i_dataB);
                            default: result_d = '0;
                        endcase
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (isdiv_q) begin
                    if (!dtry[WIDTH+1]) begin
                        hi_d = dtry[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = rs[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mac[WIDTH:1];
                    lo_d = {mac[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = lo_d;
                    rem_d    = isdiv_q ? hi_d : '0;
                    ovf_d    = !isdiv_q && (hi_d != '0);
                    cb_d     = 1'b0;
                    divz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            isdiv_q  <= 1'b0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            rem_q    <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
            divz_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            isdiv_q  <= isdiv_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
            divz_q   <= divz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_result      = result_q;
    assign o_remainder   = rem_q;
    assign o_checkbranch = cb_q;
    assign o_ovf         = ovf_q;
    assign o_divz        = divz_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes model results, a negedge monitor checks each o_done.
module tb_alu_mc;
    localparam int W = 13;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] o_result, o_remainder;
    logic         o_checkbranch, o_ovf, o_divz, o_busy, o_done;

    alu_mc #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_opcode(op),
        .i_dataA(a), .i_dataB(b),
        .o_result(o_result), .o_remainder(o_remainder), .o_checkbranch(o_checkbranch),
        .o_ovf(o_ovf), .o_divz(o_divz), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         cb;
        logic         ovf;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input int unsigned x, input int unsigned y);
        exp_t e;
        longint unsigned m, p;
        m = (64'd1 << W) - 1;
        e = '{res: '0, rem: '0, cb: 1'b0, ovf: 1'b0, dz: 1'b0};
        case (o)
            1: begin p = longint'(x) + y; e.res = W'(p & m); e.ovf = (p > m); end
            2: begin e.res = W'(x - y); e.ovf = (x < y); end
            3: begin p = longint'(x) * y; e.res = W'(p & m); e.ovf = ((p >> W) != 0); end
            4: if (y == 0) begin e.res = W'(m); e.rem = W'(x); e.dz = 1'b1; end
               else begin e.res = W'(x / y); e.rem = W'(x % y); end
            5: e.res = W'(x & y);
            6: e.res = W'(x | y);
            7: e.res = W'(x ^ y);
            8, 13, 14: e.res = W'(x + y);
            9:  e.cb = (x == y);
            10: e.cb = (x > y);
            11: e.cb = (x < y);
            12: e.cb = (x != y);
            15: e.res = (y >= W) ? '0 : W'(longint'(x) << y);
            default: e.res = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got o_done=1 expected no completion");
            end else begin
                e = sb.pop_front();
                chk("result", o_result, e.res);
                chk("remainder", o_remainder, e.rem);
                chk("checkbranch", o_checkbranch, e.cb);
                chk("ovf", o_ovf, e.ovf);
                chk("divz", o_divz, e.dz);
                chk("busy_in_done", o_busy, 0);
            end
        end
    end

    // mode: 0 plain, 1 poke i_start during ITER, 2 poke i_start during DONE
    task automatic run_op(input logic [3:0] o, input int unsigned x, input int unsigned y, input int mode);
        exp_t e;
        int lat = 0, busyc = 0, exp_lat, exp_busy;
        bit seen = 0;
        e = model(o, x, y);
        exp_lat  = (o == 3 || (o == 4 && y != 0)) ? W + 1 : 1;
        exp_busy = exp_lat - 1;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = W'(x); b = W'(y);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (o_busy) busyc++;
            if (o_done) seen = 1;
            if (mode == 1 && i == 5) begin start = 1'b1; op = 4'd1; a = 1; b = 1; end
            if (mode == 1 && i == 6) start = 1'b0;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no o_done expected one within 40 cycles");
        end else begin
            chk("latency", lat, exp_lat);
            chk("busy_cycles", busyc, exp_busy);
        end
        if (mode == 2) begin start = 1'b1; op = 4'd1; a = 1; b = 1; end
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_result", o_result, e.res);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_result"}, o_result, 0);
        chk({name, "_rem"}, o_remainder, 0);
        chk({name, "_flags"}, {o_checkbranch, o_ovf, o_divz, o_busy, o_done}, 0);
    endtask

    initial begin
        int saw;
        logic [3:0] ro;
        int unsigned rx, ry;
        #3 chk_zero("reset");
        #9 rst_n = 1'b1;

        run_op(1, 8000, 500, 0);
        run_op(2, 5, 7, 0);
        run_op(3, 100, 50, 0);
        run_op(3, 200, 100, 0);
        run_op(4, 8191, 7, 0);
        run_op(4, 9, 0, 0);
        run_op(11, 3, 5, 0);
        run_op(1, 1, 1, 0);
        run_op(9, 4, 5, 0);
        run_op(3, 1234, 77, 1);
        run_op(4, 5000, 3, 2);
        run_op(15, 1, 13, 0);
        run_op(15, 3, 4, 0);
        run_op(3, 8191, 8191, 0);
        run_op(4, 3, 8191, 0);

        // asynchronous reset in the middle of a cycle
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        #3 rst_n = 1'b1;
        saw = 0;
        repeat (5) begin @(negedge clk); if (o_done) saw++; end
        chk("idle_no_done", saw, 0);

        // reset during MUL iteration aborts with no completion afterwards
        @(posedge clk); #1;
        start = 1'b1; op = 4'd3; a = 13'd321; b = 13'd99;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("iter_abort");
        #10 rst_n = 1'b1;
        saw = 0;
        repeat (20) begin @(negedge clk); if (o_done) saw++; end
        chk("abort_no_done", saw, 0);
        chk("abort_result", o_result, 0);

        for (int k = 0; k < 80; k++) begin
            ro = 4'($urandom);
            rx = $urandom & 32'h1FFF;
            ry = $urandom & 32'h1FFF;
            if (ro == 4 && $urandom_range(0, 3) == 0) ry = 0;
            if (ro == 15) ry = $urandom_range(0, 15);
            if (ro >= 9 && ro <= 12 && $urandom_range(0, 2) == 0) ry = rx;
            run_op(ro, rx, ry, int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
